// File: rtl/subtractor4_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package sub_pkg;

  localparam int SUB_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/subtractor4_serial_if.sv
// Operand/result handshake bundle for subtractor4_serial; master drives operands, slave is the subtractor.
interface subtractor4_serial_if import sub_pkg::*; #(
  parameter int WIDTH = SUB_WIDTH_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             busy;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, borrow_out, busy
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, borrow_out, busy
  );

endinterface

// File: rtl/subtractor4_serial_full_subtractor_1bit.sv
// Combinational one-bit full subtractor: diff = a ^ b ^ bin, borrow out when a < b + bin.
module full_subtractor_1bit (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic diff_o,
  output logic bout_o
);

  assign diff_o = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/subtractor4_serial.sv
// Bit-serial ripple-borrow subtractor (a - b - bin, LSB first, one bit per clock) behind valid/ready.
// Build option: define SUB_CLAMP_EN to saturate diff to zero whenever the final borrow is set.
module subtractor4_serial import sub_pkg::*; #(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  subtractor4_serial_if.slave  io
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef SUB_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] diff_q;
  logic [CNT_W-1:0] cnt_q;
  logic             br_q;
  logic             borrow_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic             bit_d;
  logic             br_d;
  logic [WIDTH-1:0] acc_d;

  // Unsigned saturation: an underflowed result collapses to zero when clamping is built in.
  function automatic logic [WIDTH-1:0] sat_result(input logic [WIDTH-1:0] raw,
                                                  input logic             borrow);
    return (CLAMP_EN && borrow) ? '0 : raw;
  endfunction

  full_subtractor_1bit u_fsub (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .bin_i  (br_q),
    .diff_o (bit_d),
    .bout_o (br_d)
  );

  // Each new difference bit enters at the MSB so the LSB lands in bit 0 after WIDTH shifts.
  assign acc_d = {bit_d, acc_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (io.in_valid && in_ready_q) begin
            a_q        <= io.a;
            b_q        <= io.b;
            br_q       <= io.bin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_d;
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            diff_q      <= sat_result(acc_d, br_d);
            borrow_q    <= br_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          // Result registers are untouched here, so they stay stable under backpressure.
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign io.in_ready   = in_ready_q;
  assign io.out_valid  = out_valid_q;
  assign io.diff       = diff_q;
  assign io.borrow_out = borrow_q;
  assign io.busy       = busy_q;

endmodule

// File: tb/tb_subtractor4_serial.sv
// Self-checking bench for subtractor4_serial: a WIDTH=4 and a WIDTH=8 instance against an arithmetic model.
module tb_subtractor4_serial;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  subtractor4_serial_if #(.WIDTH(4)) if4 ();
  subtractor4_serial_if #(.WIDTH(8)) if8 ();

  subtractor4_serial #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .io(if4.slave));
  subtractor4_serial #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .io(if8.slave));

`ifdef SUB_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  // Reference: plain integer subtraction, then reduce modulo 2^w.
  function automatic void ref_sub(input int w, input int a, input int b, input int bin,
                                  output int d, output bit bo);
    int r;
    r  = a - b - bin;
    bo = (r < 0);
    d  = r & ((1 << w) - 1);
    if (CLAMP && bo) d = 0;
  endfunction

  // Drives one operation on the 4-bit instance and returns what it produced.
  task automatic op4(input int a, input int b, input int bin,
                     output int lat, output int d, output bit bo);
    if4.in_valid = 1'b1;
    if4.a = 4'(a); if4.b = 4'(b); if4.bin = bin[0];
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    if4.a = 4'($urandom); if4.b = 4'($urandom); if4.bin = 1'($urandom);
    lat = 0;
    while (!if4.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    d  = int'(if4.diff);
    bo = if4.borrow_out;
    if4.out_ready = 1'b1;
    @(posedge clk); #1;
    if4.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (if4.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", if4.in_ready); end
    checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", if4.out_valid); end
    checks++; if (if4.diff !== 4'd0) begin errors++; $display("FAIL reset_diff: got %0d expected 0", if4.diff); end
    checks++; if (if4.borrow_out !== 1'b0) begin errors++; $display("FAIL reset_borrow: got %b expected 0", if4.borrow_out); end
    checks++; if (if4.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", if4.busy); end
    checks++; if (if8.in_ready !== 1'b1 || if8.out_valid !== 1'b0) begin errors++; $display("FAIL reset_w8: got in_ready=%b out_valid=%b expected 1/0", if8.in_ready, if8.out_valid); end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    int av[4] = '{9, 5, 0, 7};
    int bv[4] = '{5, 9, 0, 7};
    int cv[4] = '{0, 0, 1, 0};
    int ed[4] = '{4, 12, 15, 0};
    bit eb[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int lat, d;
    bit bo;
    for (int i = 0; i < 4; i++) begin
      int exp_d;
      exp_d = (CLAMP && eb[i]) ? 0 : ed[i];
      op4(av[i], bv[i], cv[i], lat, d, bo);
      checks++; if (d !== exp_d) begin errors++; $display("FAIL directed_diff %0d-%0d-%0d: got %0d expected %0d", av[i], bv[i], cv[i], d, exp_d); end
      checks++; if (bo !== eb[i]) begin errors++; $display("FAIL directed_borrow %0d-%0d-%0d: got %b expected %b", av[i], bv[i], cv[i], bo, eb[i]); end
      checks++; if (lat !== 4) begin errors++; $display("FAIL directed_latency %0d-%0d-%0d: got %0d expected 4", av[i], bv[i], cv[i], lat); end
    end
  endtask

  task automatic test_random();
    int a, b, c, lat, d, exp_d;
    bit bo, exp_bo;
    for (int i = 0; i < 24; i++) begin
      a = int'($urandom_range(15)); b = int'($urandom_range(15)); c = int'($urandom_range(1));
      if (i == 0) begin a = 0; b = 15; c = 1; end
      ref_sub(4, a, b, c, exp_d, exp_bo);
      op4(a, b, c, lat, d, bo);
      checks++; if (d !== exp_d || bo !== exp_bo || lat !== 4)
        begin errors++; $display("FAIL random %0d-%0d-%0d: got d=%0d bo=%b lat=%0d expected d=%0d bo=%b lat=4", a, b, c, d, bo, lat, exp_d, exp_bo); end
    end
  endtask

  task automatic test_backpressure();
    int exp_d, n, d0;
    bit exp_bo, bo0;
    ref_sub(4, 12, 3, 1, exp_d, exp_bo);
    if4.in_valid = 1'b1; if4.a = 4'd12; if4.b = 4'd3; if4.bin = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!if4.out_valid && n < 50) begin
      if4.in_valid = ~if4.in_valid;
      if4.a = 4'($urandom); if4.b = 4'($urandom); if4.bin = 1'($urandom);
      checks++; if (if4.in_ready !== 1'b0 || if4.busy !== 1'b1) begin errors++; $display("FAIL bp_run_ctrl: got in_ready=%b busy=%b expected 0/1", if4.in_ready, if4.busy); end
      @(posedge clk); #1;
      n++;
    end
    d0 = int'(if4.diff); bo0 = if4.borrow_out;
    checks++; if (d0 !== exp_d || bo0 !== exp_bo) begin errors++; $display("FAIL bp_result: got d=%0d bo=%b expected d=%0d bo=%b", d0, bo0, exp_d, exp_bo); end
    for (int k = 0; k < 3; k++) begin
      if4.in_valid = 1'b1; if4.a = 4'($urandom); if4.b = 4'($urandom);
      @(posedge clk); #1;
      checks++; if (if4.out_valid !== 1'b1 || int'(if4.diff) !== d0 || if4.borrow_out !== bo0 || if4.in_ready !== 1'b0)
        begin errors++; $display("FAIL bp_hold cycle %0d: got ov=%b d=%0d bo=%b ir=%b expected ov=1 d=%0d bo=%b ir=0", k, if4.out_valid, if4.diff, if4.borrow_out, if4.in_ready, d0, bo0); end
    end
    if4.in_valid = 1'b0;
    if4.out_ready = 1'b1;
    @(posedge clk); #1;
    if4.out_ready = 1'b0;
    checks++; if (if4.out_valid !== 1'b0 || if4.in_ready !== 1'b1 || if4.busy !== 1'b0)
      begin errors++; $display("FAIL bp_release: got ov=%b ir=%b busy=%b expected 0/1/0", if4.out_valid, if4.in_ready, if4.busy); end
    @(posedge clk); #1;
    checks++; if (if4.busy !== 1'b0) begin errors++; $display("FAIL bp_no_latch: got busy=%b expected 0", if4.busy); end
  endtask

  task automatic test_reset_midrun();
    int lat, d;
    bit bo;
    if4.in_valid = 1'b1; if4.a = 4'd14; if4.b = 4'd1; if4.bin = 1'b0;
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (if4.in_ready !== 1'b1 || if4.out_valid !== 1'b0 || if4.diff !== 4'd0 || if4.busy !== 1'b0)
      begin errors++; $display("FAIL midrun_reset: got ir=%b ov=%b d=%0d busy=%b expected 1/0/0/0", if4.in_ready, if4.out_valid, if4.diff, if4.busy); end
    repeat (6) begin
      @(posedge clk); #1;
      checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL midrun_discard: got out_valid=%b expected 0", if4.out_valid); end
    end
    op4(3, 1, 0, lat, d, bo);
    checks++; if (d !== 2 || bo !== 1'b0 || lat !== 4) begin errors++; $display("FAIL midrun_next: got d=%0d bo=%b lat=%0d expected 2/0/4", d, bo, lat); end
  endtask

  task automatic test_width8();
    int lat, d, exp_d;
    bit bo, exp_bo;
    int acc_cyc[$];
    int exp_q[$];
    int sent, got, cyc;
    bit hs, take;
    // Single directed op with latency measurement.
    if8.in_valid = 1'b1; if8.a = 8'd200; if8.b = 8'd55; if8.bin = 1'b0;
    @(posedge clk); #1;
    if8.in_valid = 1'b0; if8.a = 8'd1; if8.b = 8'd2;
    lat = 0;
    while (!if8.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++; if (if8.diff !== 8'd145 || if8.borrow_out !== 1'b0 || lat !== 8)
      begin errors++; $display("FAIL w8_200_55: got d=%0d bo=%b lat=%0d expected 145/0/8", if8.diff, if8.borrow_out, lat); end
    if8.out_ready = 1'b1;
    @(posedge clk); #1;
    // Back-to-back: operands always offered, results always taken.
    sent = 0; got = 0;
    if8.in_valid = 1'b1;
    if8.a = 8'($urandom); if8.b = 8'($urandom); if8.bin = 1'($urandom);
    for (cyc = 0; cyc < 200 && got < 5; cyc++) begin
      hs = if8.in_valid && if8.in_ready;
      take = if8.out_valid && if8.out_ready;
      d = int'(if8.diff); bo = if8.borrow_out;
      if (hs) begin
        ref_sub(8, int'(if8.a), int'(if8.b), int'(if8.bin), exp_d, exp_bo);
        exp_q.push_back({exp_bo, exp_d[7:0]});
        acc_cyc.push_back(cyc);
      end
      @(posedge clk); #1;
      if (hs) begin
        sent++;
        if (sent == 5) if8.in_valid = 1'b0;
        if8.a = 8'($urandom); if8.b = 8'($urandom); if8.bin = 1'($urandom);
      end
      if (take) begin
        int e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        checks++; if ({bo, 8'(d)} !== e[8:0] || e < 0)
          begin errors++; $display("FAIL w8_b2b_result %0d: got d=%0d bo=%b expected d=%0d bo=%b", got, d, bo, e[7:0], e[8]); end
        got++;
      end
    end
    checks++; if (got !== 5) begin errors++; $display("FAIL w8_b2b_count: got %0d results expected 5", got); end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      checks++; if (acc_cyc[i] - acc_cyc[i-1] !== 10)
        begin errors++; $display("FAIL w8_b2b_spacing %0d: got %0d cycles expected 10", i, acc_cyc[i] - acc_cyc[i-1]); end
    end
    if8.out_ready = 1'b0;
  endtask

  initial begin
    if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.bin = 1'b0; if4.out_ready = 1'b0;
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.bin = 1'b0; if8.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midrun();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
